// File: rtl/term_fire_sequencer.sv
// Flight-termination sequencer: hold-to-arm, prioritised masked requests, fixed fire pulse,
// cooldown and lifetime fire limit. Define TERM_WDOG_EN to add the heartbeat watchdog request.
module term_fire_sequencer #(
    parameter int NREQ         = 3,
    parameter int ARM_HOLD     = 16,
    parameter int PULSE_LEN    = 100,
    parameter int COOLDOWN_LEN = 50,
    parameter int MAX_FIRES    = 2,
    parameter int CNT_W        = 16,
    parameter int WDOG_LEN     = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            arm_req,
    input  logic            disarm,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_mask,
    input  logic            heartbeat,
    output logic            fire,
    output logic            armed,
    output logic            busy,
    output logic [NREQ-1:0] cause,
    output logic [3:0]      fire_count,
    output logic            done,
    output logic            wdog_trip
);
    typedef enum logic [2:0] {
        S_SAFE, S_ARMING, S_ARMED, S_FIRING, S_COOLDOWN, S_SPENT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   cause_q, cause_d;
    logic [3:0]        fcnt_q, fcnt_d, fcnt_inc;
    logic              dis_lat_q, dis_lat_d;
    logic              fire_q, armed_q, busy_q, done_q;
    logic [NREQ-1:0]   pend;
    logic              wdog_req;
    logic              wdog_take;

    assign pend = req & req_mask;

`ifdef TERM_WDOG_EN
    logic             hb_q;
    logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic             wdog_pend_q, wdog_pend_d;
    logic             wdog_trip_q;
    logic             in_window;

    assign in_window = (state_q == S_ARMED) || (state_q == S_COOLDOWN);
    assign wdog_req  = (wdog_cnt_q == CNT_W'(WDOG_LEN)) || wdog_pend_q;

    always_comb begin
        wdog_cnt_d  = '0;
        wdog_pend_d = 1'b0;
        if (in_window) begin
            if (heartbeat && !hb_q)
                wdog_cnt_d = '0;
            else if (wdog_cnt_q < CNT_W'(WDOG_LEN))
                wdog_cnt_d = wdog_cnt_q + 1'b1;
            else
                wdog_cnt_d = wdog_cnt_q;
            // A timeout reached while cooling down must survive a later heartbeat.
            wdog_pend_d = wdog_pend_q ||
                          ((state_q == S_COOLDOWN) && (wdog_cnt_q == CNT_W'(WDOG_LEN)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_q        <= 1'b0;
            wdog_cnt_q  <= '0;
            wdog_pend_q <= 1'b0;
            wdog_trip_q <= 1'b0;
        end else begin
            hb_q        <= heartbeat;
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_pend_q <= wdog_pend_d;
            wdog_trip_q <= wdog_trip_q | wdog_take;
        end
    end

    assign wdog_trip = wdog_trip_q;
`else
    logic unused_wdog;
    assign unused_wdog = heartbeat ^ (WDOG_LEN != 0);
    assign wdog_req    = 1'b0;
    assign wdog_trip   = 1'b0;
`endif

    assign fcnt_inc = (fcnt_q < 4'(MAX_FIRES)) ? fcnt_q + 4'd1 : fcnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        fcnt_d    = fcnt_q;
        dis_lat_d = dis_lat_q;
        wdog_take = 1'b0;
        case (state_q)
            S_SAFE: begin
                if (arm_req && !disarm) begin
                    state_d = S_ARMING;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_ARMING: begin
                if (!arm_req || disarm) begin
                    state_d = S_SAFE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(ARM_HOLD)) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ARMED: begin
                if (disarm) begin
                    state_d = S_SAFE;
                end else if (pend != '0) begin
                    state_d   = S_FIRING;
                    cnt_d     = CNT_W'(1);
                    cause_d   = pend & (~pend + 1'b1);  // isolate lowest set bit
                    dis_lat_d = 1'b0;
                end else if (wdog_req) begin
                    state_d   = S_FIRING;
                    cnt_d     = CNT_W'(1);
                    cause_d   = '0;
                    dis_lat_d = 1'b0;
                    wdog_take = 1'b1;
                end
            end
            S_FIRING: begin
                dis_lat_d = dis_lat_q | disarm;
                if (cnt_q == CNT_W'(PULSE_LEN)) begin
                    fcnt_d = fcnt_inc;
                    cnt_d  = '0;
                    if (fcnt_inc == 4'(MAX_FIRES)) begin
                        state_d = S_SPENT;
                    end else if (dis_lat_q || disarm) begin
                        state_d = S_SAFE;
                    end else begin
                        state_d = S_COOLDOWN;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (disarm) begin
                    state_d = S_SAFE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(COOLDOWN_LEN)) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SPENT: ;
            default: begin
                state_d = S_SAFE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_SAFE;
            cnt_q     <= '0;
            cause_q   <= '0;
            fcnt_q    <= '0;
            dis_lat_q <= 1'b0;
            fire_q    <= 1'b0;
            armed_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            fcnt_q    <= fcnt_d;
            dis_lat_q <= dis_lat_d;
            fire_q    <= (state_d == S_FIRING);
            armed_q   <= (state_d == S_ARMED) || (state_d == S_COOLDOWN);
            busy_q    <= (state_d == S_FIRING);
            done_q    <= (state_d == S_SPENT);
        end
    end

    assign fire       = fire_q;
    assign armed      = armed_q;
    assign busy       = busy_q;
    assign cause      = cause_q;
    assign fire_count = fcnt_q;
    assign done       = done_q;
endmodule
